note_tone_gen: RTL
==================

Name: note_tone_gen

Overview:
- Consumer end of the music engine's 5-bit note-code interface; the song FSMs drive this interface.
- Accepts a held note code and turns it into a 1-bit square-wave audio output for the speaker/DAC pin.
- Filters glitches on the code and inserts a short articulation gap whenever the note changes.
- Treats codes 25..31 as rest (silence).

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles a new code must stay stable before it is accepted (range 1..255).
- GAP_CYCLES, 250000: silent articulation cycles between accepting a new pitched note and starting its tone (1..2^24-1; 5 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = play, 0 = force silence.
- note  in  5  note code: 0..24 = semitones from A3, 25..31 = rest.
- audio  out  1  square-wave output.
- playing  out  1  high while in state PLAY.
- cur_note  out  5  last accepted note code.

Behaviour:
- Reset (async, rst_n=0):
  - audio=0, playing=0, cur_note=25, state=SILENT.
  - note_q=25, all counters 0.
  - Takes effect immediately, including mid-PLAY or mid-GAP.
- Input register: note_q <= note on every clk edge. All decisions use note_q only; note itself is never used combinationally.
- Pitch table (ROM, 18-bit, combinational from cand/cur_note):
  - H[n] = round(50e6 / (2 * 220 * 2^(n/12))) for n = 0..24.
  - Anchors: H[0]=113636, H[7]=75843, H[12]=56818, H[24]=28409.
  - Every entry is >= 2.
- States: SILENT, SETTLE, GAP, PLAY.
- Change detect: in any state, if enable=1 and note_q != cur_note and note_q != cand (or the state is not SETTLE):
  - enter SETTLE, cand <= note_q, settle_cnt <= 1.
- SETTLE:
  - While note_q == cand: settle_cnt increments.
  - When settle_cnt reaches SETTLE_CYCLES, accept: cur_note <= cand.
    - cand >= 25 → SILENT, with audio 0 and playing 0 on the same edge.
    - Otherwise → GAP, with gap_cnt <= GAP_CYCLES-1 and audio 0.
  - If note_q returns to cur_note before acceptance: abandon and return to the prior state. The tone keeps running with phase undisturbed; audio/playing are not altered while settling.
  - If note_q changes to a third value: restart SETTLE with the new cand.
- GAP:
  - audio=0, playing=0, gap_cnt decrements.
  - At gap_cnt == 0 → PLAY: audio <= 1, half_cnt <= H[cur_note]-1, playing <= 1.
- PLAY:
  - half_cnt decrements each cycle.
  - At 0: audio toggles and half_cnt reloads H[cur_note]-1.
  - Result: each half-period is exactly H cycles; full period is 2H.
- Latency: first audio rise occurs on the edge SETTLE_CYCLES+GAP_CYCLES+1 edges after the edge that loads the new code into note_q.
- Identical consecutive codes sustain with no gap and no phase reset; the engine holds notes by repeating a code.
- Rest→rest changes (e.g. 25→31) are accepted silently: no gap, and cur_note updates.
- enable=0 (any state):
  - Next edge: state=SILENT, audio=0, playing=0, cur_note=25.
  - Re-enabling with the same pitched note therefore retriggers through SETTLE and GAP.
- Simultaneous enable fall and note change: enable wins.

Test Plan:
(Bench uses SETTLE_CYCLES=4, GAP_CYCLES=10, clk 50 MHz.)
1. Assert rst_n=0 mid-PLAY with note=12 → audio=0, playing=0, cur_note=25 immediately, with no clk edge required; release → stays SILENT until a new code arrives.
2. enable=1, note 25→12 → audio rises on edge 15 after note_q updates; playing=1; audio high for exactly 56818 cycles, then low for 56818, repeating.
3. While playing 12, drive note=7 for 2 cycles then back to 12 → no retrigger; cur_note stays 12; audio phase and period unchanged.
4. Change 12→7 and hold → after 4 cycles, cur_note=7, audio=0, playing=0 for 10 cycles; then tone starts with half-period 75843.
5. Drive note=25, then 31, then 24 → audio=0 and playing=0 for rests, cur_note tracks 25 then 31; 24 plays with half-period 28409 after the gap.
6. Drop enable mid-note 12 → audio=0 on the next edge, cur_note=25; raise enable with note still 12 → full SETTLE+GAP retrigger; first rise 15 edges later.

Source files
------------

// File: rtl/note_tone_gen.sv
// Note-code consumer: glitch-filters a held 5-bit note code, inserts an articulation
// gap on pitch changes and produces a 1-bit square wave for the speaker pin.
module note_tone_gen #(
    parameter int SETTLE_CYCLES = 16,
    parameter int GAP_CYCLES    = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [4:0] note,
    output logic       audio,
    output logic       playing,
    output logic [4:0] cur_note
);

    typedef enum logic [1:0] {SILENT, SETTLE, GAP, PLAY} state_t;

    localparam logic [4:0]  REST       = 5'd25;
    localparam logic [7:0]  SETTLE_MAX = 8'(SETTLE_CYCLES);
    localparam logic [23:0] GAP_LOAD   = 24'(GAP_CYCLES - 1);

    state_t      state, state_n, prior, prior_n;
    logic [4:0]  note_q, cand, cand_n, cur_n;
    logic [7:0]  settle_cnt, settle_n;
    logic [23:0] gap_cnt, gap_n;
    logic [17:0] half_cnt, half_n, half_len;
    logic        audio_n, playing_n;

    // Half-period in clk cycles: round(50e6 / (2 * 220 * 2^(n/12)))
    function automatic logic [17:0] pitch(input logic [4:0] n);
        case (n)
            5'd0:  pitch = 18'd113636;
            5'd1:  pitch = 18'd107258;
            5'd2:  pitch = 18'd101238;
            5'd3:  pitch = 18'd95556;
            5'd4:  pitch = 18'd90193;
            5'd5:  pitch = 18'd85131;
            5'd6:  pitch = 18'd80353;
            5'd7:  pitch = 18'd75843;
            5'd8:  pitch = 18'd71586;
            5'd9:  pitch = 18'd67569;
            5'd10: pitch = 18'd63776;
            5'd11: pitch = 18'd60197;
            5'd12: pitch = 18'd56818;
            5'd13: pitch = 18'd53629;
            5'd14: pitch = 18'd50619;
            5'd15: pitch = 18'd47778;
            5'd16: pitch = 18'd45097;
            5'd17: pitch = 18'd42566;
            5'd18: pitch = 18'd40177;
            5'd19: pitch = 18'd37922;
            5'd20: pitch = 18'd35793;
            5'd21: pitch = 18'd33784;
            5'd22: pitch = 18'd31888;
            5'd23: pitch = 18'd30098;
            5'd24: pitch = 18'd28409;
            default: pitch = 18'd2;
        endcase
    endfunction

    assign half_len = pitch(cur_note);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SILENT;
            prior      <= SILENT;
            note_q     <= REST;
            cand       <= REST;
            cur_note   <= REST;
            settle_cnt <= '0;
            gap_cnt    <= '0;
            half_cnt   <= '0;
            audio      <= 1'b0;
            playing    <= 1'b0;
        end else begin
            state      <= state_n;
            prior      <= prior_n;
            note_q     <= note;
            cand       <= cand_n;
            cur_note   <= cur_n;
            settle_cnt <= settle_n;
            gap_cnt    <= gap_n;
            half_cnt   <= half_n;
            audio      <= audio_n;
            playing    <= playing_n;
        end
    end

    always_comb begin
        state_n   = state;
        prior_n   = prior;
        cand_n    = cand;
        cur_n     = cur_note;
        settle_n  = settle_cnt;
        gap_n     = gap_cnt;
        half_n    = half_cnt;
        audio_n   = audio;
        playing_n = playing;

        // The tone keeps running while a candidate settles, so phase survives a glitch
        if (playing) begin
            if (half_cnt == 18'd0) begin
                audio_n = ~audio;
                half_n  = half_len - 18'd1;
            end else begin
                half_n = half_cnt - 18'd1;
            end
        end

        if (!enable) begin
            state_n   = SILENT;
            audio_n   = 1'b0;
            playing_n = 1'b0;
            cur_n     = REST;
        end else if (note_q != cur_note && (state != SETTLE || note_q != cand)) begin
            state_n  = SETTLE;
            cand_n   = note_q;
            settle_n = 8'd1;
            if (state != SETTLE)
                prior_n = state;
        end else begin
            case (state)
                SETTLE: begin
                    if (note_q == cur_note) begin
                        state_n = prior;
                    end else if (settle_cnt == SETTLE_MAX) begin
                        cur_n     = cand;
                        audio_n   = 1'b0;
                        playing_n = 1'b0;
                        if (cand >= REST) begin
                            state_n = SILENT;
                        end else begin
                            state_n = GAP;
                            gap_n   = GAP_LOAD;
                        end
                    end else begin
                        settle_n = settle_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == 24'd0) begin
                        state_n   = PLAY;
                        audio_n   = 1'b1;
                        playing_n = 1'b1;
                        half_n    = half_len - 18'd1;
                    end else begin
                        gap_n = gap_cnt - 24'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
